// File: rtl/instr_fetch_pkg.sv
// Shared fetch-unit definitions: FSM state encodings, fault codes and
// the width of the WAIT-state timeout counter.
package instr_fetch_pkg;

    typedef enum logic [2:0] {
        ST_REQ  = 3'd0,
        ST_WAIT = 3'd1,
        ST_HOLD = 3'd2,
        ST_ADV  = 3'd3,
        ST_HALT = 3'd4
    } fetch_state_e;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    localparam int TIMEOUT_W = 8;

    // Instruction words are 32-bit aligned; any low address bit set is a fault.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch unit connection bundle: PC link, instruction memory port,
// decoder handshake and fault reporting.
interface instr_fetch_if;

    logic [31:0] pc;
    logic        pc_adv;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        flush;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        fault;
    logic [1:0]  fault_cause;

    // Fetch unit side
    modport master (
        input  pc, mem_gnt, mem_rvalid, mem_rdata, flush, instr_ready,
        output pc_adv, mem_req, mem_addr, instr_valid, instr, instr_pc,
               fault, fault_cause
    );

    // Environment side: program counter, memory and decoder
    modport slave (
        output pc, mem_gnt, mem_rvalid, mem_rdata, flush, instr_ready,
        input  pc_adv, mem_req, mem_addr, instr_valid, instr, instr_pc,
               fault, fault_cause
    );

endinterface

// File: rtl/instr_fetch_timeout.sv
// WAIT-state watchdog: 8-bit counter with clear/enable and a compare
// output that goes high once the count equals TIMEOUT.
module fetch_timeout
    import instr_fetch_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT);

    logic [TIMEOUT_W-1:0] count_q;
    logic [TIMEOUT_W-1:0] count_d;

    // Next count: clear has priority; saturate so the counter never wraps.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {TIMEOUT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit = (count_q == LIMIT);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests the word at the current PC, holds it
// for the decoder until accepted, then pulses the PC advance.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    fetch_state_e state_q, state_d;
    logic         req_fresh_q, req_fresh_d;   // first REQ cycle: address comes straight from pc
    logic [31:0]  addr_q, addr_d;
    logic         discard_q, discard_d;       // flush seen in WAIT, drop the next response
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         fault_q, fault_d;
    logic [1:0]   cause_q, cause_d;

    logic         tmo_clr;
    logic         tmo_en;
    logic         tmo_hit;
    logic [31:0]  req_addr;
    logic         mem_req_c;
    logic         instr_valid_c;
    logic         pc_adv_c;

    fetch_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (tmo_clr),
        .en  (tmo_en),
        .hit (tmo_hit)
    );

    // Next-state and handshake outputs; fault beats flush beats handshakes.
    always_comb begin
        state_d       = state_q;
        req_fresh_d   = req_fresh_q;
        addr_d        = addr_q;
        discard_d     = discard_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        fault_d       = fault_q;
        cause_d       = cause_q;
        tmo_clr       = 1'b0;
        tmo_en        = 1'b0;
        mem_req_c     = 1'b0;
        instr_valid_c = 1'b0;
        pc_adv_c      = 1'b0;
        // The PC only settles the cycle REQ is entered, so that cycle
        // forwards pc directly and later cycles use the latched copy.
        req_addr      = req_fresh_q ? bus.pc : addr_q;

        case (state_q)
            ST_REQ: begin
                addr_d      = req_addr;
                req_fresh_d = 1'b0;
                if (is_misaligned(req_addr[1:0])) begin
                    fault_d = 1'b1;
                    cause_d = FAULT_MISALIGN;
                    state_d = ST_HALT;
                end else if (bus.flush) begin
                    req_fresh_d = 1'b1;
                end else begin
                    mem_req_c = 1'b1;
                    if (bus.mem_gnt) begin
                        state_d   = ST_WAIT;
                        tmo_clr   = 1'b1;
                        discard_d = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                tmo_en = 1'b1;
                if (tmo_hit) begin
                    fault_d = 1'b1;
                    cause_d = FAULT_TIMEOUT;
                    state_d = ST_HALT;
                end else if (bus.mem_rvalid) begin
                    if (discard_q || bus.flush) begin
                        state_d     = ST_REQ;
                        req_fresh_d = 1'b1;
                        discard_d   = 1'b0;
                    end else begin
                        instr_d    = bus.mem_rdata;
                        instr_pc_d = addr_q;
                        state_d    = ST_HOLD;
                    end
                end else if (bus.flush) begin
                    discard_d = 1'b1;
                end
            end
            ST_HOLD: begin
                instr_valid_c = !bus.flush;
                if (bus.flush) begin
                    state_d     = ST_REQ;
                    req_fresh_d = 1'b1;
                end else if (bus.instr_ready) begin
                    state_d = ST_ADV;
                end
            end
            ST_ADV: begin
                pc_adv_c    = 1'b1;
                state_d     = ST_REQ;
                req_fresh_d = 1'b1;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d     = ST_REQ;
                req_fresh_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_REQ;
            req_fresh_q <= 1'b1;
            addr_q      <= '0;
            discard_q   <= 1'b0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            fault_q     <= 1'b0;
            cause_q     <= FAULT_NONE;
        end else begin
            state_q     <= state_d;
            req_fresh_q <= req_fresh_d;
            addr_q      <= addr_d;
            discard_q   <= discard_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
        end
    end

    // Handshakes are held low while reset is applied.
    assign bus.mem_req     = mem_req_c && !rst;
    assign bus.mem_addr    = ((state_q == ST_REQ) && !rst) ? req_addr : addr_q;
    assign bus.instr_valid = instr_valid_c && !rst;
    assign bus.pc_adv      = pc_adv_c && !rst;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.fault       = fault_q;
    assign bus.fault_cause = cause_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: consumes the address published by `program_counter` (`pc_out`), reads the instruction word from instruction memory through a request/response handshake, and presents it to decode with a valid/ready handshake. It also generates the PC's `clk_en` advance pulse once decode has accepted the word. The unit sits between `program_counter`, the instruction memory port and the decoder, and it paces the whole single-issue CPU.

## Interface

Parameters:
- `TIMEOUT`, default 255: maximum number of cycles spent in WAIT before a bus fault is raised; range 1..255.

Ports:
- `clk`  in  1  system clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc`  in  32  current fetch address, driven by `program_counter.pc_out`.
- `pc_adv`  out  1  one-cycle pulse to `program_counter.clk_en`.
- `mem_req`  out  1  read request.
- `mem_addr`  out  32  word address; equals `pc` latched at request time.
- `mem_gnt`  in  1  memory accepts the request this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  instruction word.
- `flush`  in  1  aborts the fetch that is in progress.
- `instr_valid`  out  1  the instruction on `instr` is valid.
- `instr`  out  32  fetched instruction word.
- `instr_pc`  out  32  address `instr` was fetched from.
- `instr_ready`  in  1  decoder accepts the instruction.
- `fault`  out  1  sticky error flag; cleared only by `rst`.
- `fault_cause`  out  2  01 = misaligned pc, 10 = bus timeout, 00 = none.

## Operation

- FSM states: REQ, WAIT, HOLD, ADV, HALT.
- Reset sends the FSM to REQ. All outputs reset to 0: `pc_adv`, `mem_req`, `mem_addr`, `instr_valid`, `instr`, `instr_pc`, `fault` and `fault_cause`.
- **REQ**
  - On entry, latch `pc` into the address register.
  - If `pc[1:0] != 0`: set `fault`, set `fault_cause` = 01, go to HALT.
  - Otherwise hold `mem_req` = 1 with a stable `mem_addr` until `mem_gnt` = 1.
  - On grant, go to WAIT and clear the timeout counter.
- **WAIT**
  - On `mem_rvalid`: capture `mem_rdata` into `instr`, the latched address into `instr_pc`, and go to HOLD.
  - The timeout counter (8 bit) increments every cycle. On reaching `TIMEOUT`: set `fault`, set `fault_cause` = 10, go to HALT.
- **HOLD**
  - `instr_valid` = 1; `instr` and `instr_pc` are stable.
  - When `instr_valid && instr_ready`, go to ADV.
- **ADV**
  - `pc_adv` = 1 for exactly this cycle, then go to REQ.
  - REQ samples `pc` one cycle after ADV, once the PC has updated.
- **HALT**
  - All handshake outputs are 0 and `fault` is held. Only `rst` leaves this state.
- **flush** (with `rst` inactive)
  - In REQ: drop `mem_req`, relatch `pc` next cycle, stay in REQ.
  - In WAIT: set a discard flag. The next `mem_rvalid` is dropped, then return to REQ. The timeout counter keeps running while the discard is pending.
  - In HOLD: deassert `instr_valid`, go to REQ with no `pc_adv`.
  - Ignored in ADV and HALT.
- **Priority:** `rst` > fault detection > `flush` > handshakes.
- **Simultaneous events**
  - `flush` and `mem_rvalid` in the same WAIT cycle: the data is discarded, then go to REQ.
  - `flush` and `instr_ready` in the same HOLD cycle: flush wins, and no `pc_adv` is issued.
- At most one outstanding memory request.
- `pc_adv` is never asserted outside ADV.

## Timing

- Best-case loop, with `mem_gnt` in the REQ cycle, `mem_rvalid` one cycle after grant, and `instr_ready` tied high:
  - REQ at cycle 0, WAIT at 1, HOLD at 2, ADV at 3, next REQ at 4.
  - Result: 4 cycles per instruction.
- `instr_valid` rises in the cycle after `mem_rvalid` (registered).
- `mem_req` rises in the first cycle after `rst` deasserts.
- `fault` is registered and visible the cycle after the condition is detected.
- Reset mid-fetch: the FSM returns to REQ and any in-flight response is ignored. The memory is required to drop outstanding reads on the same `rst`.

## Structure

- Shared CPU package/header (alongside the PC's select encodings):
  - FSM state encodings (3 bit).
  - `FAULT_NONE`/`FAULT_MISALIGN`/`FAULT_TIMEOUT` constants.
- Sub-module `fetch_timeout`: 8-bit counter with clear/enable inputs and a `TIMEOUT` compare output. Everything else is flat.

## Test plan

- **Reset then fetch:** PC = 0, `mem_gnt` immediate, `rdata` = 0x2001_0005 one cycle later, ready high.
  - `mem_addr` = 0; `instr` = 0x20010005 and `instr_pc` = 0 at cycle 2; `pc_adv` pulse at cycle 3; next `mem_addr` = 4.
- **Backpressure:** hold `instr_ready` low for 5 cycles in HOLD.
  - `instr` and `instr_valid` stay stable; no `pc_adv` until the cycle after ready rises.
- **Flush in WAIT:** flush one cycle after grant, `rvalid` two cycles later with 0xDEAD_BEEF.
  - 0xDEADBEEF never appears on `instr`; a new request is issued at the current `pc`.
- **Misaligned pc:** drive `pc` = 0x0000_0006.
  - `fault` = 1 and `fault_cause` = 01; `mem_req` is never asserted; the state persists until `rst`.
- **Timeout:** `TIMEOUT` = 10, `mem_gnt` given, `rvalid` never arrives.
  - `fault_cause` = 10 the cycle after the count reaches 10.
  - Asserting `rst` afterwards clears `fault` and restarts fetch at `pc`.
- **Stalled grant:** `mem_gnt` held low for 3 cycles while `pc` is stable.
  - `mem_req` stays high with `mem_addr` unchanged throughout; `pc_adv` count equals the number of accepted instructions over 100 random ready patterns.
